// File: rtl/irda_fir_flag_seq.sv
`timescale 1ns/1ps
// irda_fir_flag_seq_fifo: small generic FIFO with synchronous flush.
// Latency: a push is visible at o_head_dat the clk after it is written.
// Backpressure: o_full blocks pushes; a push while full or during flush is dropped.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_flush             synchronous empty; wins over push/pop
//   i_push, i_push_dat  write request and data
//   i_pop               read request (ignored when empty)
//   o_head_dat          oldest entry (valid when !o_empty)
//   o_full, o_empty     occupancy flags
module irda_fir_flag_seq_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push  = i_push && !o_full && !i_flush;
  assign w_do_pop   = i_pop && !o_empty && !i_flush;
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read when the pointers say valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// irda_fir_flag_seq: queued 4PPM flag (PA/STA/STO) and zero-fill chip sequencer.
// Latency: a queued command's chip 0 appears on the first chip_en after the push cycle.
// Backpressure: cmd_ready low when the command queue is full or abort is asserted.
//
// Ports:
//   clk, wb_rst_n              clock, async active-low reset
//   chip_en                    one-clk chip strobe
//   cmd_valid/cmd_ready        command handshake; cmd_flag (00 zero, 01 PA,
//                              10 STA, 11 STO), cmd_count (reps / zero chips)
//   abort                      synchronous flush of queue and engine
//   chip_o, chip_valid_o       registered chip and its valid qualifier
//   eof_o                      pulse with the last chip of each command
//   busy_o                     registered: queue non-empty or engine running
module irda_fir_flag_seq #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             wb_rst_n,
  input  logic             chip_en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_flag,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             chip_o,
  output logic             chip_valid_o,
  output logic             eof_o,
  output logic             busy_o
);

  // Length counter must hold 16*(2^CNT_W-1) for PA and 32 for STA/STO.
  localparam int LEN_W = (CNT_W + 4 > 6) ? CNT_W + 4 : 6;

  localparam logic [1:0] FLAG_ZERO = 2'b00;
  localparam logic [1:0] FLAG_PA   = 2'b01;
  localparam logic [1:0] FLAG_STA  = 2'b10;
  localparam logic [1:0] FLAG_STO  = 2'b11;

  // MSB is chip 0 (first transmitted).
  localparam logic [15:0] PA_PAT  = 16'b1000_0000_1010_1000;
  localparam logic [31:0] STA_PAT = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
  localparam logic [31:0] STO_PAT = 32'b0000_1100_0000_1100_0000_0110_0000_0110;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef struct packed {
    logic [1:0]       flag;
    logic [CNT_W-1:0] count;
  } cmd_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_flag;
  logic [1:0]       w_flag_nxt;
  logic [4:0]       r_idx;
  logic [4:0]       w_idx_nxt;
  logic [LEN_W-1:0] r_left;
  logic [LEN_W-1:0] w_left_nxt;
  logic             r_chip;
  logic             w_chip_nxt;
  logic             r_chip_vld;
  logic             w_chip_vld_nxt;
  logic             r_eof;
  logic             w_eof_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  cmd_t             w_cmd_in;
  cmd_t             w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [LEN_W-1:0] w_cnt1;
  logic [LEN_W-1:0] w_total;

  function automatic logic chip_bit(input logic [1:0] f, input logic [4:0] idx);
    logic b;
    b = 1'b0;
    case (f)
      FLAG_PA:  b = PA_PAT[4'd15 - idx[3:0]];
      FLAG_STA: b = STA_PAT[5'd31 - idx];
      FLAG_STO: b = STO_PAT[5'd31 - idx];
      default:  b = 1'b0;
    endcase
    return b;
  endfunction

  assign cmd_ready      = !w_full && !abort;
  assign w_push         = cmd_valid && cmd_ready;
  assign w_cmd_in.flag  = cmd_flag;
  assign w_cmd_in.count = cmd_count;

  irda_fir_flag_seq_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_cmd_q (
    .clk        (clk),
    .rst_n      (wb_rst_n),
    .i_flush    (abort),
    .i_push     (w_push),
    .i_push_dat (w_cmd_in),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Total chip count of the head command; a count of 0 behaves as 1.
  always_comb begin
    w_cnt1 = (w_head.count == '0) ? LEN_W'(1) : LEN_W'(w_head.count);
    case (w_head.flag)
      FLAG_ZERO: w_total = w_cnt1;
      FLAG_PA:   w_total = w_cnt1 << 4;
      default:   w_total = LEN_W'(32);
    endcase
  end

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state    <= S_IDLE;
      r_flag     <= FLAG_ZERO;
      r_idx      <= '0;
      r_left     <= '0;
      r_chip     <= 1'b0;
      r_chip_vld <= 1'b0;
      r_eof      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_flag     <= w_flag_nxt;
      r_idx      <= w_idx_nxt;
      r_left     <= w_left_nxt;
      r_chip     <= w_chip_nxt;
      r_chip_vld <= w_chip_vld_nxt;
      r_eof      <= w_eof_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // r_idx is the index of the next chip to emit; r_left counts chips not yet
  // emitted. After the final chip the engine always drops to IDLE: a queued
  // command is then loaded by the IDLE branch on the very next strobe, which
  // keeps back-to-back commands gapless.
  always_comb begin
    w_state_nxt    = r_state;
    w_flag_nxt     = r_flag;
    w_idx_nxt      = r_idx;
    w_left_nxt     = r_left;
    w_chip_nxt     = r_chip;
    w_chip_vld_nxt = r_chip_vld;
    w_eof_nxt      = 1'b0;
    w_busy_nxt     = (r_state == S_RUN) || !w_empty;
    w_pop          = 1'b0;

    if (abort) begin
      w_state_nxt    = S_IDLE;
      w_idx_nxt      = '0;
      w_left_nxt     = '0;
      w_chip_nxt     = 1'b0;
      w_chip_vld_nxt = 1'b0;
      w_busy_nxt     = 1'b0;
    end else if (chip_en) begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            w_pop          = 1'b1;
            w_flag_nxt     = w_head.flag;
            w_chip_nxt     = chip_bit(w_head.flag, 5'd0);
            w_chip_vld_nxt = 1'b1;
            w_idx_nxt      = 5'd1;
            w_left_nxt     = w_total - LEN_W'(1);
            // A single-chip zero fill is finished by its own load.
            if (w_total == LEN_W'(1)) begin
              w_eof_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RUN;
            end
          end else begin
            w_chip_nxt     = 1'b0;
            w_chip_vld_nxt = 1'b0;
          end
        end
        S_RUN: begin
          w_chip_nxt = chip_bit(r_flag, r_idx);
          // PA wraps through the low 4 index bits on each repetition.
          w_idx_nxt  = r_idx + 5'd1;
          w_left_nxt = r_left - LEN_W'(1);
          if (r_left == LEN_W'(1)) begin
            w_eof_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign chip_o       = r_chip;
  assign chip_valid_o = r_chip_vld;
  assign eof_o        = r_eof;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_irda_fir_flag_seq.sv
`timescale 1ns/1ps
module tb_irda_fir_flag_seq;

  logic       clk;
  logic       wb_rst_n;
  logic       chip_en;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_flag;
  logic [7:0] cmd_count;
  logic       abort;
  logic       chip_o;
  logic       chip_valid_o;
  logic       eof_o;
  logic       busy_o;

  irda_fir_flag_seq #(.CNT_W(8), .DEPTH(2)) dut (
    .clk          (clk),
    .wb_rst_n     (wb_rst_n),
    .chip_en      (chip_en),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_flag     (cmd_flag),
    .cmd_count    (cmd_count),
    .abort        (abort),
    .chip_o       (chip_o),
    .chip_valid_o (chip_valid_o),
    .eof_o        (eof_o),
    .busy_o       (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic chip; logic eof; } exp_t;
  typedef struct { logic [1:0] flag; logic [7:0] cnt; int div; int exp_len; int exp_ones; } vec_t;

  exp_t        sb[$];
  int          eof_idx[$];
  vec_t        vt[8];
  int          n_chk, n_fail;
  int          n_chips, n_eof, n_ones;
  logic [31:0] first32;
  logic        busy_at_eof;
  int          ce_div, div_cnt, pend_old;
  logic        ce_on, acc, ce_s, ab_s, rdy_s;
  logic [15:0] pa_v;   // bit i = chip i
  logic [31:0] sta_v, sto_v;
  int          pa_ones[4]  = '{0, 8, 10, 12};
  int          sta_ones[8] = '{4, 5, 12, 13, 17, 18, 25, 26};
  int          sto_ones[8] = '{4, 5, 12, 13, 21, 22, 29, 30};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic sb_add(input logic [1:0] f, input logic [7:0] c);
    int   cc, n;
    exp_t e;
    cc = (c == 8'd0) ? 1 : int'(c);
    n  = (f == 2'b00) ? cc : (f == 2'b01) ? 16 * cc : 32;
    for (int i = 0; i < n; i++) begin
      case (f)
        2'b01:   e.chip = pa_v[i % 16];
        2'b10:   e.chip = sta_v[i];
        2'b11:   e.chip = sto_v[i];
        default: e.chip = 1'b0;
      endcase
      e.eof = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic clr();
    n_chips = 0; n_eof = 0; n_ones = 0; first32 = '0; busy_at_eof = 1'b0;
    eof_idx.delete();
  endtask

  // One clk: drive strobe, sample handshake at negedge, check outputs #1 after posedge.
  task automatic cycle();
    exp_t e;
    chip_en  = ce_on && (div_cnt == 0);
    div_cnt  = (div_cnt + 1 >= ce_div) ? 0 : div_cnt + 1;
    pend_old = sb.size();
    @(negedge clk);
    acc = cmd_valid && cmd_ready; rdy_s = cmd_ready; ce_s = chip_en; ab_s = abort;
    @(posedge clk); #1;
    if (ab_s) begin
      sb.delete();
      chk("eof_abort", eof_o, 0);
    end else if (ce_s) begin
      if (chip_valid_o) begin
        chk("sb_has_entry", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("chip", chip_o, e.chip);
          chk("eof", eof_o, e.eof);
        end
        if (n_chips < 32) first32[n_chips] = chip_o;
        if (chip_o) n_ones++;
        if (eof_o) begin eof_idx.push_back(n_chips); n_eof++; busy_at_eof = busy_o; end
        n_chips++;
      end else begin
        chk("no_gap_pending", pend_old, 0);
        chk("eof_idle", eof_o, 0);
      end
    end else begin
      chk("eof_hold", eof_o, 0);
    end
    if (acc) begin
      sb_add(cmd_flag, cmd_count);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic push(input logic [1:0] f, input logic [7:0] c);
    logic done;
    done = 1'b0;
    cmd_valid = 1'b1; cmd_flag = f; cmd_count = c;
    for (int k = 0; k < 400 && !done; k++) begin
      cycle();
      done = acc;
    end
    chk("push_accept", done, 1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; ce_div = 1; div_cnt = 0; ce_on = 1'b0;
    pa_v = '0; sta_v = '0; sto_v = '0;
    foreach (pa_ones[i])  pa_v[pa_ones[i]]   = 1'b1;
    foreach (sta_ones[i]) sta_v[sta_ones[i]] = 1'b1;
    foreach (sto_ones[i]) sto_v[sto_ones[i]] = 1'b1;

    //       flag   cnt      div len   ones
    vt[0] = '{2'b10, 8'd0,   4,  32,   8};
    vt[1] = '{2'b11, 8'd7,   1,  32,   8};
    vt[2] = '{2'b01, 8'd0,   2,  16,   4};
    vt[3] = '{2'b01, 8'd2,   1,  32,   8};
    vt[4] = '{2'b00, 8'd0,   1,  1,    0};
    vt[5] = '{2'b00, 8'd5,   3,  5,    0};
    vt[6] = '{2'b01, 8'd255, 1,  4080, 1020};
    vt[7] = '{2'b10, 8'd200, 1,  32,   8};

    wb_rst_n = 1'b0; chip_en = 1'b0; cmd_valid = 1'b0; cmd_flag = 2'b00;
    cmd_count = 8'd0; abort = 1'b0;
    clr();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_chip", chip_o, 0);
    chk("rst_vld", chip_valid_o, 0);
    chk("rst_eof", eof_o, 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk) wb_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", cmd_ready, 1);
    chk("rst_busy_rel", busy_o, 0);
    ce_on = 1'b1;

    // Single commands from the table
    for (int v = 0; v < 8; v++) begin
      ce_div = vt[v].div; div_cnt = 0; clr();
      push(vt[v].flag, vt[v].cnt);
      for (int k = 0; k < vt[v].exp_len * vt[v].div + 40 && n_eof == 0; k++) cycle();
      chk($sformatf("v%0d_eofs", v), n_eof, 1);
      chk($sformatf("v%0d_len", v), n_chips, vt[v].exp_len);
      chk($sformatf("v%0d_ones", v), n_ones, vt[v].exp_ones);
      chk($sformatf("v%0d_busy_at_eof", v), busy_at_eof, 1);
      cycle();
      chk($sformatf("v%0d_busy_fall", v), busy_o, 0);
      chk($sformatf("v%0d_sb_drained", v), sb.size(), 0);
      if (vt[v].flag == 2'b10) chk($sformatf("v%0d_sta_mask", v), first32, sta_v);
      repeat (3) cycle();
    end

    // PA x3 then STA, gapless, strobe every clk
    ce_div = 1; div_cnt = 0; clr();
    push(2'b01, 8'd3);
    push(2'b10, 8'd0);
    for (int k = 0; k < 300 && n_eof < 2; k++) cycle();
    chk("pa3sta_len", n_chips, 80);
    chk("pa3sta_eofs", n_eof, 2);
    chk("pa3sta_eof0", (eof_idx.size() > 0) ? eof_idx[0] : -1, 47);
    chk("pa3sta_eof1", (eof_idx.size() > 1) ? eof_idx[1] : -1, 79);
    repeat (3) cycle();

    // PA count 0 then zero-fill count 0
    clr();
    push(2'b01, 8'd0);
    push(2'b00, 8'd0);
    for (int k = 0; k < 100 && n_eof < 2; k++) cycle();
    chk("min_len", n_chips, 17);
    chk("min_eof0", (eof_idx.size() > 0) ? eof_idx[0] : -1, 15);
    chk("min_eof1", (eof_idx.size() > 1) ? eof_idx[1] : -1, 16);
    repeat (3) cycle();

    // Queue full while engine busy
    ce_div = 4; div_cnt = 0; clr();
    push(2'b10, 8'd0);
    push(2'b11, 8'd0);
    push(2'b01, 8'd1);
    cycle();
    chk("rdy_full", cmd_ready, 0);
    for (int k = 0; k < 300 && n_eof == 0; k++) cycle();
    chk("rdy_full_at_eof", cmd_ready, 0);
    ce_s = 1'b0;
    for (int k = 0; k < 10 && !ce_s; k++) cycle();
    chk("rdy_after_pop", cmd_ready, 1);
    for (int k = 0; k < 600 && n_eof < 3; k++) cycle();
    chk("fill_eofs", n_eof, 3);
    chk("fill_len", n_chips, 80);
    repeat (3) cycle();

    // Abort at STO chip 10 with PA queued
    ce_div = 1; div_cnt = 0; clr();
    push(2'b11, 8'd0);
    push(2'b01, 8'd1);
    for (int k = 0; k < 100 && n_chips < 11; k++) cycle();
    chk("abort_reach", n_chips, 11);
    abort = 1'b1; cmd_valid = 1'b1; cmd_flag = 2'b01; cmd_count = 8'd1;
    cycle();
    chk("abort_rdy", rdy_s, 0);
    chk("abort_acc", acc, 0);
    abort = 1'b0; cmd_valid = 1'b0;
    chk("abort_chip", chip_o, 0);
    chk("abort_vld", chip_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    repeat (40) cycle();
    chk("abort_no_eof", n_eof, 0);
    chk("abort_no_chips", n_chips, 11);
    clr();
    push(2'b01, 8'd1);
    for (int k = 0; k < 100 && n_eof == 0; k++) cycle();
    chk("post_abort_len", n_chips, 16);
    chk("post_abort_first", first32[15:0], pa_v);
    repeat (3) cycle();

    // Asynchronous reset mid-PA
    clr();
    push(2'b01, 8'd3);
    for (int k = 0; k < 100 && !(n_chips >= 17 && chip_o); k++) cycle();
    chk("pre_rst_chip", chip_o, 1);
    #1 wb_rst_n = 1'b0;
    #1;
    chk("arst_chip", chip_o, 0);
    chk("arst_vld", chip_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_eof", eof_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) wb_rst_n = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("arst_rdy", cmd_ready, 1);
    chk("arst_busy_rel", busy_o, 0);
    clr();
    repeat (20) cycle();
    chk("arst_q_empty", n_chips, 0);
    chk("arst_vld_idle", chip_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irda_fir_flag_seq.md
Name: irda_fir_flag_seq

Overview:
- Parametrised successor to the single-flag FIR generator.
- Emits 4PPM flag chip streams (PA, STA, STO) and zero-fill runs from a small command queue, gaplessly back-to-back, at one chip per chip strobe.
- PA repeat count and zero-fill length are given per command; abort is supported.
- Sits between the FIR transmit controller (command source) and the FIR chip serialiser/mux.

Parameters:
- CNT_W, 8, width of the per-command count field (PA repetitions or zero-fill chips).
- DEPTH, 2, command queue depth in entries; power of two, minimum 2.

Ports:
- clk, input, 1, system clock.
- wb_rst_n, input, 1, asynchronous active-low reset.
- chip_en, input, 1, chip strobe; one clk pulse per chip period (8 Mchip/s rate).
- cmd_valid, input, 1, command offer.
- cmd_ready, output, 1, queue can accept a command (queue not full, no abort this cycle).
- cmd_flag, input, 2, 00 zero-fill, 01 PA, 10 STA, 11 STO.
- cmd_count, input, CNT_W, PA repetitions (01) or zero chips (00); ignored for STA/STO; value 0 treated as 1.
- abort, input, 1, synchronous flush of queue and engine.
- chip_o, output, 1, current chip (registered).
- chip_valid_o, output, 1, chip_o belongs to a command (registered).
- eof_o, output, 1, one-clk pulse coincident with the last chip of each command.
- busy_o, output, 1, queue non-empty or engine active.

Behaviour:
- Reset (wb_rst_n low, async):
  - queue empty; engine IDLE.
  - chip_o=0, chip_valid_o=0, eof_o=0, busy_o=0.
  - cmd_ready=1 once reset is released.
- Queue:
  - DEPTH-entry FIFO of {flag, count}; push on cmd_valid & cmd_ready.
  - cmd_ready = !full & !abort (combinational).
  - Pop only on a chip_en cycle where the engine loads a new command.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- Patterns (chip index, MSB-first order of transmission; listed indices are 1, all others 0):
  - PA: 16 chips, ones at 0,8,10,12; repeated max(count,1) times.
  - STA: 32 chips, ones at 4,5,12,13,17,18,25,26.
  - STO: 32 chips, ones at 4,5,12,13,21,22,29,30.
  - Zero-fill: max(count,1) chips of 0.
- Engine states: IDLE, RUN.
  - IDLE, chip_en=1, queue non-empty: pop; chip_o<=chip 0 of the popped command; chip_valid_o<=1; go to RUN. Chip index and repetition counters are preset for the next chip.
  - IDLE, chip_en=1, queue empty: chip_o<=0, chip_valid_o<=0.
  - RUN, chip_en=1: emit the next chip.
    - On the final chip (last index of the last repetition, or the last zero chip): eof_o<=1 for that clk only.
    - If the queue is non-empty at that same cycle, the next chip_en emits chip 0 of the next command with no idle chip in between (next-command load happens on the chip_en after the final chip).
    - Otherwise the engine returns to IDLE.
  - chip_en=0: all outputs hold, except eof_o, which returns to 0.
- Latency:
  - A command pushed into an empty, idle block appears on chip_o after the first chip_en that follows the push cycle.
  - A push coincident with chip_en is not seen until the next chip_en.
- Length: PA command = 16*max(count,1) chips; STA/STO = 32 chips. Counters use CNT_W+4 bits internally; no overflow at count = 2^CNT_W-1.
- Abort (synchronous, highest priority):
  - Next clk: queue empty, engine IDLE, chip_o=0, chip_valid_o=0, eof_o=0.
  - No eof pulse is produced for the aborted command.
  - A push in the abort cycle is dropped (cmd_ready is 0).
- busy_o (registered): 1 when queue non-empty or state RUN; falls the clk after the final chip if the queue is empty.
- Reset mid-command: immediate return to the reset values; partial flag is discarded.

Test Plan:
- Push STA, chip_en every 4 clk -> chip_o sequence over 32 strobes has ones exactly at chip indices 4,5,12,13,17,18,25,26. eof_o is high for one clk with chip 31. busy_o falls afterwards.
- Push PA count=3 then STA while PA runs, chip_en every clk -> 48 PA chips (pattern 1000000010101000 x3), then 32 STA chips with no gap. eof_o pulses at chip 47 and chip 79.
- Push PA count=0 and zero-fill count=0 -> each is treated as 1: 16 PA chips, then one 0 chip with chip_valid_o=1, then two eof pulses.
- Fill queue (DEPTH=2) while engine busy -> cmd_ready drops to 0. A pop on the next final-chip/load chip_en reasserts cmd_ready.
- Abort at STO chip 10, with one command queued -> next clk chip_o=0, chip_valid_o=0, busy_o=0, no eof. A later push starts cleanly at chip 0.
- Assert wb_rst_n=0 asynchronously mid-PA -> outputs 0 without a clk edge. After release the queue is empty and cmd_ready=1.
